// File: rtl/register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
// Shared encodings for the register bank: command opcodes and the states of
// the re-initialisation sequencer.
// -----------------------------------------------------------------------------
package register_bank_pkg;

    // Command opcodes presented on op
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_ROT    = 2'b10;
    localparam logic [1:0] OP_REINIT = 2'b11;

    // Sequencer states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_INIT = 1'b1;

endpackage

// File: rtl/register_bank_cell.sv
// -----------------------------------------------------------------------------
// register_bank_cell
// One enable-loaded register with an asynchronous load of its own reset value.
//   ck    : clock, rising edge
//   rst_n : asynchronous active-low reset, loads RST_VAL
//   ena   : load enable
//   d     : next value, taken when ena is high
//   q     : current register contents
// -----------------------------------------------------------------------------
module register_bank_cell #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// Bank of NREG registers, each with its own reset value
// DEF(i) = INIT_BASE + i*INIT_STEP (truncated to WIDTH). Supports addressed
// writes, a one-cycle rotate towards register 0, and a sequenced restore of
// all defaults (one register per cycle) with a done pulse at the end.
//   ck, rst_n              : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  : command handshake; ready is low while restoring
//   op                     : NOP / WRITE / ROTATE / REINIT
//   wr_addr, d             : WRITE target and data
//   rd_addr_a/b, rd_data_a/b : two combinational read ports (0 if out of range)
//   q_all                  : all registers, register 0 in the LSBs
//   done                   : one-cycle pulse after the last default is restored
//   err                    : one-cycle pulse after a WRITE to an address >= NREG
// -----------------------------------------------------------------------------
module register_bank
    import register_bank_pkg::*;
#(
    parameter int NREG      = 3,
    parameter int WIDTH     = 6,
    parameter int INIT_BASE = 1,
    parameter int INIT_STEP = 1,
    parameter int AW        = (NREG > 2) ? $clog2(NREG) : 1
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            op,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      d,
    input  logic [AW-1:0]         rd_addr_a,
    input  logic [AW-1:0]         rd_addr_b,
    output logic [WIDTH-1:0]      rd_data_a,
    output logic [WIDTH-1:0]      rd_data_b,
    output logic [NREG*WIDTH-1:0] q_all,
    output logic                  done,
    output logic                  err
);

    localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);
    localparam logic [AW:0]   NREG_W   = (AW + 1)'(NREG);

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] r_q [NREG];
    logic             accept;
    logic             wr_in_range;

    assign cmd_ready   = (state_q == S_IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign wr_in_range = ({1'b0, wr_addr} < NREG_W);
    assign done        = done_q;
    assign err         = err_q;

    // Sequencer: REINIT walks idx over every register, one per cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && op == OP_REINIT) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                end else if (accept && op == OP_WRITE && !wr_in_range) begin
                    err_d = 1'b1;
                end
            end
            default: begin // S_INIT
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Per-register load control. accept is never high in S_INIT because
    // cmd_ready is low there, so busy-time commands cannot reach the cells.
    for (genvar i = 0; i < NREG; i++) begin : g_cell
        localparam logic [WIDTH-1:0] DEF  = WIDTH'(INIT_BASE + i * INIT_STEP);
        localparam int               NXT  = (i + 1) % NREG;
        localparam logic [AW-1:0]    ADDR = AW'(i);

        logic             ena;
        logic [WIDTH-1:0] cd;

        always_comb begin
            ena = 1'b0;
            cd  = d;
            if (state_q == S_INIT) begin
                if (idx_q == ADDR) begin
                    ena = 1'b1;
                    cd  = DEF;
                end
            end else if (accept) begin
                if (op == OP_WRITE && wr_addr == ADDR) begin
                    ena = 1'b1;
                    cd  = d;
                end else if (op == OP_ROT) begin
                    ena = 1'b1;
                    cd  = r_q[NXT];
                end
            end
        end

        register_bank_cell #(
            .WIDTH   (WIDTH),
            .RST_VAL (DEF)
        ) u_cell (
            .ck    (ck),
            .rst_n (rst_n),
            .ena   (ena),
            .d     (cd),
            .q     (r_q[i])
        );

        assign q_all[i*WIDTH +: WIDTH] = r_q[i];
    end

    // Read muxes; addresses beyond the bank read as zero
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_addr_a == AW'(i)) rd_data_a = r_q[i];
            if (rd_addr_b == AW'(i)) rd_data_b = r_q[i];
        end
    end

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic        rst_n;
    logic        v    [2];
    logic [1:0]  opx  [2];
    logic [1:0]  wa   [2];
    logic [5:0]  dx   [2];
    logic [1:0]  ra   [2];
    logic [1:0]  rb   [2];
    logic        rdy  [2];
    logic        dn   [2];
    logic        er   [2];
    logic [5:0]  rda  [2];
    logic [5:0]  rdb  [2];
    logic [23:0] qa4;
    logic [17:0] qa3;

    // Instance 0: NREG=4; instance 1: NREG=3 (has unrepresented address 3)
    register_bank #(.NREG(4), .WIDTH(6), .INIT_BASE(1), .INIT_STEP(1)) u4 (
        .ck(ck), .rst_n(rst_n), .cmd_valid(v[0]), .cmd_ready(rdy[0]), .op(opx[0]),
        .wr_addr(wa[0]), .d(dx[0]), .rd_addr_a(ra[0]), .rd_addr_b(rb[0]),
        .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .q_all(qa4), .done(dn[0]), .err(er[0])
    );

    register_bank #(.NREG(3), .WIDTH(6), .INIT_BASE(1), .INIT_STEP(1)) u3 (
        .ck(ck), .rst_n(rst_n), .cmd_valid(v[1]), .cmd_ready(rdy[1]), .op(opx[1]),
        .wr_addr(wa[1]), .d(dx[1]), .rd_addr_a(ra[1]), .rd_addr_b(rb[1]),
        .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .q_all(qa3), .done(dn[1]), .err(er[1])
    );

    // Reference model: register contents as integers, plus remaining busy cycles
    int n_checks = 0;
    int n_err    = 0;
    int mdl [2][4];
    int nr  [2];
    int busy[2];
    bit exp_done[2];
    bit exp_err [2];

    function automatic int defv(int i);
        return (1 + i) % 64;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mdl[k][i] = (i < nr[k]) ? defv(i) : 0;
            busy[k]     = 0;
            exp_done[k] = 1'b0;
            exp_err[k]  = 1'b0;
        end
    endtask

    task automatic model_edge(int k);
        int t;
        int idx;
        exp_done[k] = 1'b0;
        exp_err[k]  = 1'b0;
        if (busy[k] > 0) begin
            idx = nr[k] - busy[k];
            mdl[k][idx] = defv(idx);
            busy[k]--;
            if (busy[k] == 0) exp_done[k] = 1'b1;
        end else if (v[k]) begin
            case (opx[k])
                2'b01: begin
                    if (int'(wa[k]) < nr[k]) mdl[k][wa[k]] = int'(dx[k]);
                    else exp_err[k] = 1'b1;
                end
                2'b10: begin
                    t = mdl[k][0];
                    for (int i = 0; i < nr[k] - 1; i++) mdl[k][i] = mdl[k][i+1];
                    mdl[k][nr[k]-1] = t;
                end
                2'b11: busy[k] = nr[k];
                default: ;
            endcase
        end
    endtask

    function automatic logic [23:0] exp_q(int k);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < nr[k]; i++) r[i*6 +: 6] = 6'(mdl[k][i]);
        return r;
    endfunction

    function automatic int exp_rd(int k, logic [1:0] a);
        return (int'(a) < nr[k]) ? mdl[k][a] : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_q(string tg);
        logic [23:0] e;
        e = exp_q(0);
        chk({tg, " u4 q_all"}, 32'(qa4), 32'(e));
        e = exp_q(1);
        chk({tg, " u3 q_all"}, 32'(qa3), 32'(e[17:0]));
    endtask

    task automatic check_reads(string tg);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d rd_a", tg, k), 32'(rda[k]), 32'(exp_rd(k, ra[k])));
            chk($sformatf("%s u%0d rd_b", tg, k), 32'(rdb[k]), 32'(exp_rd(k, rb[k])));
        end
    endtask

    task automatic check_all(string tg);
        check_q(tg);
        check_reads(tg);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d ready", tg, k), 32'(rdy[k]), 32'(busy[k] == 0));
            chk($sformatf("%s u%0d done", tg, k), 32'(dn[k]), 32'(exp_done[k]));
            chk($sformatf("%s u%0d err", tg, k), 32'(er[k]), 32'(exp_err[k]));
        end
    endtask

    // Inputs are driven just after a falling edge; reads are checked before
    // the rising edge (old contents), everything again at the next falling edge.
    task automatic step(string tg);
        #2;
        check_reads({tg, " pre"});
        @(posedge ck);
        model_edge(0);
        model_edge(1);
        @(negedge ck);
        check_all(tg);
    endtask

    task automatic write0(int a, int val);
        v[0] = 1'b1; opx[0] = 2'b01; wa[0] = 2'(a); dx[0] = 6'(val);
        step($sformatf("wr%0d", a));
    endtask

    initial begin
        nr[0] = 4;
        nr[1] = 3;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0; opx[k] = 2'b00; wa[k] = '0; dx[k] = '0; ra[k] = '0; rb[k] = '0;
        end
        model_reset();
        repeat (2) @(negedge ck);
        check_q("in_reset");
        rst_n = 1'b1;
        @(negedge ck);
        check_all("reset_release");

        // Write register 2 with a same-address read on both ports
        ra[0] = 2'd2; rb[0] = 2'd2;
        write0(2, 6'h2A);
        v[0] = 1'b0;
        step("wr2_visible");
        write0(2, 3);

        // Four rotates return to the starting contents
        ra[0] = 2'd0; rb[0] = 2'd3;
        v[0] = 1'b1; opx[0] = 2'b10;
        for (int n = 0; n < 4; n++) step($sformatf("rot%0d", n));

        // Fill with 0x3F, then REINIT while a WRITE is held on the bus
        for (int i = 0; i < 4; i++) write0(i, 6'h3F);
        opx[0] = 2'b11;
        step("reinit_accept");
        opx[0] = 2'b01; dx[0] = 6'h15;
        for (int n = 0; n < 4; n++) begin
            wa[0] = 2'(n);
            step($sformatf("init_busy%0d", n));
        end
        v[0] = 1'b0;
        step("after_done");

        // Out-of-range write on the three-register bank
        v[1] = 1'b1; opx[1] = 2'b01; wa[1] = 2'd3; dx[1] = 6'h15; ra[1] = 2'd3; rb[1] = 2'd2;
        step("err_write");
        v[1] = 1'b0;
        step("err_clear");

        // Reset in the middle of a REINIT sequence
        for (int i = 0; i < 4; i++) write0(i, 6'h3F);
        opx[0] = 2'b11;
        step("reinit2_accept");
        v[0] = 1'b0;
        step("reinit2_c0");
        step("reinit2_c1");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_q("async_reset");
        @(negedge ck);
        rst_n = 1'b1;
        step("post_reset0");
        step("post_reset1");

        // Random traffic on both banks
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 2; k++) begin
                v[k]   = ($urandom_range(0, 3) != 0);
                opx[k] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                wa[k]  = 2'($urandom);
                dx[k]  = 6'($urandom);
                ra[k]  = 2'($urandom);
                rb[k]  = 2'($urandom);
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of NREG enable-loaded registers, each WIDTH bits wide, with its own non-zero reset value. It adds addressed writes, two combinational read ports, a one-cycle rotate of all contents, and a sequenced re-initialisation state machine. It sits in the datapath wherever the design needs a set of preloaded constants or working registers, and replaces individually instantiated fixed-value registers.

## Interface
Parameters:
- NREG, 3: number of registers; at least 2.
- WIDTH, 6: bits per register.
- INIT_BASE, 1: reset value of register 0.
- INIT_STEP, 1: increment between consecutive reset values.
- AW, $clog2(NREG): address width; minimum 1.

Ports:
- ck  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: command accepted when cmd_valid and cmd_ready are both high.
- op  in  2: 00 NOP, 01 WRITE, 10 ROTATE, 11 REINIT.
- wr_addr  in  AW: target register for WRITE.
- d  in  WIDTH: write data.
- rd_addr_a, rd_addr_b  in  AW: read addresses.
- rd_data_a, rd_data_b  out  WIDTH: combinational read data.
- q_all  out  NREG*WIDTH: all registers concatenated; register 0 in the LSBs.
- done  out  1: one-cycle pulse when REINIT completes.
- err  out  1: one-cycle pulse when an accepted WRITE targets an address ≥ NREG.

## Operation
Default value:
- DEF(i) = (INIT_BASE + i*INIT_STEP) mod 2^WIDTH.
- Computed at elaboration; truncated to WIDTH.

Reset (rst_n low):
- r[i] = DEF(i) immediately, without waiting for a clock edge.
- FSM = IDLE, index counter = 0, done = 0, err = 0.
- cmd_ready = 1 once rst_n is high.

FSM states:
- IDLE
  - cmd_ready = 1.
  - An accepted WRITE, ROTATE or NOP executes in the same edge; the FSM stays in IDLE.
  - An accepted REINIT moves the FSM to INIT and clears idx to 0. No register changes on that edge.
- INIT
  - cmd_ready = 0; cmd_valid is ignored.
  - Each edge: r[idx] <= DEF(idx), then idx increments.
  - On the edge that writes idx = NREG-1: go to IDLE and pulse done for the following cycle.

Commands:
- WRITE: if wr_addr < NREG, r[wr_addr] <= d; otherwise no register changes and err pulses for one cycle.
- ROTATE: r[i] <= r[(i+1) mod NREG] for all i; register 0's old value moves to register NREG-1.
- NOP: no change.

Read ports:
- rd_data_x = r[rd_addr_x], or 0 if rd_addr_x ≥ NREG.
- Both ports are purely combinational and may use the same address.

Boundary conditions:
- A write and a read of the same address in one cycle: the read returns the old value; the new value is visible after the edge.
- cmd_valid low: nothing happens, regardless of op.
- Reset during INIT: all registers return to defaults immediately, the FSM goes to IDLE, and no done pulse is produced.

## Timing
- WRITE and ROTATE: 1-cycle latency; the result is visible on q_all and the read ports right after the accepting edge.
- REINIT: the accept edge plus NREG edges. cmd_ready is low for exactly NREG cycles, and done is high in the cycle after the last default write.
- err and done are registered single-cycle pulses.
- Back-to-back commands are supported: one command per cycle while cmd_ready is high.

## Structure
- Package register_bank_pkg:
  - op encodings: OP_NOP, OP_WRITE, OP_ROT, OP_REINIT.
  - FSM state encodings: S_IDLE, S_INIT.
- Sub-module register_bank_cell, one instance per register:
  - Parameters: WIDTH, RST_VAL.
  - Ports: ck, rst_n, ena, d, q.
  - Asynchronous load of RST_VAL on reset.
  - The top level computes each cell's ena and d.
- The top level contains the FSM, idx counter, command decode, read multiplexers and the err/done flops.

## Test plan
Configuration for all scenarios: NREG=4, WIDTH=6, INIT_BASE=1, INIT_STEP=1.
1. Release reset → q_all registers = 1,2,3,4; cmd_ready=1; done=0; err=0.
2. WRITE addr 2, d=0x2A → next cycle rd_data_a(addr 2) = 0x2A; registers = 1,2,0x2A,4; err stays 0.
3. ROTATE from 1,2,3,4 → 2,3,4,1; three more ROTATEs → 1,2,3,4 again.
4. WRITE 0x3F to all four registers, then REINIT with cmd_valid held high and op=WRITE during busy → cmd_ready low for 4 cycles, no writes accepted, done pulses once, registers = 1,2,3,4.
5. WRITE addr 5 is not representable with AW=2, so use NREG=3 (AW=2): WRITE addr 3 → err high for one cycle; registers unchanged at 1,2,3.
6. Assert rst_n low after 2 INIT cycles following REINIT (registers previously 0x3F) → registers = 1,2,3,4 immediately; after release, cmd_ready=1 and no done pulse.
